// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared codes and types for the pipeline hazard controller
//
// Purpose: forwarding select codes, controller state encodings, select widths
// and the packed bundle of stage-register control outputs.
// Ports: none (package).
package pipe_hazard_ctrl_pkg;

  // Width of the forwarding selects latched into ID/EX for each ALU operand.
  localparam int MUX_EX_REDIR_DATAA_BIT = 2;
  localparam int MUX_EX_REDIR_DATAB_BIT = 2;

  // Forwarding select codes: where the ID-stage operand should be taken from.
  localparam logic [1:0] REDIR_NONE = 2'd0;
  localparam logic [1:0] REDIR_EX   = 2'd1;
  localparam logic [1:0] REDIR_DM   = 2'd2;
  localparam logic [1:0] REDIR_WB   = 2'd3;

  typedef enum logic [1:0] {
    PHC_RUN    = 2'd0,
    PHC_DRAIN  = 2'd1,
    PHC_HALTED = 2'd2
  } phc_state_e;

  // Every stage-register control in one bundle. clr fields are active-low.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_stall;
    logic if_id_clr;
    logic id_ex_en;
    logic id_ex_clr;
    logic ex_dm_en;
    logic ex_dm_clr;
    logic dm_wb_en;
    logic dm_wb_clr;
    logic halted;
  } ctrl_t;

  // Normal flow: everything advances, nothing cleared.
  localparam ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_stall: 1'b0, if_id_clr: 1'b1,
    id_ex_en: 1'b1, id_ex_clr: 1'b1, ex_dm_en: 1'b1, ex_dm_clr: 1'b1,
    dm_wb_en: 1'b1, dm_wb_clr: 1'b1, halted: 1'b0
  };

  // Data-memory wait: hold every register and the PC, clear nothing.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_stall: 1'b0, if_id_clr: 1'b1,
    id_ex_en: 1'b0, id_ex_clr: 1'b1, ex_dm_en: 1'b0, ex_dm_clr: 1'b1,
    dm_wb_en: 1'b0, dm_wb_clr: 1'b1, halted: 1'b0
  };

  // Frozen after halt; contents are kept.
  localparam ctrl_t CTRL_HALTED = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_stall: 1'b0, if_id_clr: 1'b1,
    id_ex_en: 1'b0, id_ex_clr: 1'b1, ex_dm_en: 1'b0, ex_dm_clr: 1'b1,
    dm_wb_en: 1'b0, dm_wb_clr: 1'b1, halted: 1'b1
  };

  // While reset is held: nothing enabled, every stage register cleared.
  localparam ctrl_t CTRL_RESET = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_redir_sel.sv
// rtl/pipe_hazard_ctrl_redir_sel.sv - forwarding select for one ID-stage source operand
//
// Purpose: picks the youngest in-flight writer (EX > DM > WB) of a source
// register and reports whether the EX-stage writer matched, which the parent
// uses for load-use detection. Purely combinational.
// Ports:
//   use_i                     operand is actually read by the ID instruction
//   req_i[4:0]                source register number
//   {ex,dm,wb}_w_en_i         stage instruction writes the register file
//   {ex,dm,wb}_w_req_i[4:0]   destination register of that stage
//   sel_o[W-1:0]              forwarding select (REDIR_NONE/EX/DM/WB)
//   ex_match_o                EX-stage writer targets this operand
module pipe_hazard_ctrl_redir_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int W = MUX_EX_REDIR_DATAA_BIT
) (
  input  logic         use_i,
  input  logic [4:0]   req_i,
  input  logic         ex_w_en_i,
  input  logic [4:0]   ex_w_req_i,
  input  logic         dm_w_en_i,
  input  logic [4:0]   dm_w_req_i,
  input  logic         wb_w_en_i,
  input  logic [4:0]   wb_w_req_i,
  output logic [W-1:0] sel_o,
  output logic         ex_match_o
);

  logic live;
  logic dm_match;
  logic wb_match;

  always_comb begin
    // $0 is hard-wired zero, so it never needs forwarding.
    live       = use_i && (req_i != 5'd0);
    ex_match_o = live && ex_w_en_i && (ex_w_req_i == req_i);
    dm_match   = live && dm_w_en_i && (dm_w_req_i == req_i);
    wb_match   = live && wb_w_en_i && (wb_w_req_i == req_i);

    sel_o = W'(REDIR_NONE);
    if (ex_match_o) begin
      sel_o = W'(REDIR_EX);
    end else if (dm_match) begin
      sel_o = W'(REDIR_DM);
    end else if (wb_match) begin
      sel_o = W'(REDIR_WB);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage-register control, hazard detection and halt sequencing
//
// Purpose: drives en/clr/stall of IF/ID, ID/EX, EX/DM, DM/WB, the PC enable and
// the forwarding selects latched into ID/EX. Handles load-use stalls, EX-stage
// branch mispredict flushes, data-memory wait and syscall halt drain/resume.
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN adds stall_cycles/flush_count.
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   id_req_a/b, id_use_a/b         ID-stage source operands
//   ex_regfile_w_en/req_w, ex_is_load, dm_*/wb_* writer info per stage
//   ex_mispredict, ex_halt, dm_busy, go   hazard and sequencing events
//   pc_en, *_en, *_clr (active-low), if_id_stall   stage-register controls
//   redir_a/b                      forwarding selects
//   halted                         core frozen after halt
//   stall_cycles, flush_count      performance counters (macro builds only)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIR_BIT         = MUX_EX_REDIR_DATAA_BIT,
  parameter int HALT_DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count,
`endif
  input  logic [4:0]           id_req_a,
  input  logic [4:0]           id_req_b,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 ex_regfile_w_en,
  input  logic [4:0]           ex_regfile_req_w,
  input  logic                 ex_is_load,
  input  logic                 dm_regfile_w_en,
  input  logic [4:0]           dm_regfile_req_w,
  input  logic                 wb_regfile_w_en,
  input  logic [4:0]           wb_regfile_req_w,
  input  logic                 ex_mispredict,
  input  logic                 ex_halt,
  input  logic                 dm_busy,
  input  logic                 go,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_stall,
  output logic                 if_id_clr,
  output logic                 id_ex_en,
  output logic                 id_ex_clr,
  output logic                 ex_dm_en,
  output logic                 ex_dm_clr,
  output logic                 dm_wb_en,
  output logic                 dm_wb_clr,
  output logic [REDIR_BIT-1:0] redir_a,
  output logic [REDIR_BIT-1:0] redir_b,
  output logic                 halted
);

  // Counter counts down to 0 inclusive, giving HALT_DRAIN_CYCLES drain cycles.
  localparam logic [1:0] DRAIN_LOAD = 2'(HALT_DRAIN_CYCLES - 1);

  phc_state_e           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  ctrl_t                ctrl;
  logic                 load_use;
  logic                 ex_match_a, ex_match_b;
  logic [REDIR_BIT-1:0] sel_a, sel_b;

  pipe_hazard_ctrl_redir_sel #(.W(REDIR_BIT)) u_redir_a (
    .use_i      (id_use_a),
    .req_i      (id_req_a),
    .ex_w_en_i  (ex_regfile_w_en),
    .ex_w_req_i (ex_regfile_req_w),
    .dm_w_en_i  (dm_regfile_w_en),
    .dm_w_req_i (dm_regfile_req_w),
    .wb_w_en_i  (wb_regfile_w_en),
    .wb_w_req_i (wb_regfile_req_w),
    .sel_o      (sel_a),
    .ex_match_o (ex_match_a)
  );

  pipe_hazard_ctrl_redir_sel #(.W(REDIR_BIT)) u_redir_b (
    .use_i      (id_use_b),
    .req_i      (id_req_b),
    .ex_w_en_i  (ex_regfile_w_en),
    .ex_w_req_i (ex_regfile_req_w),
    .dm_w_en_i  (dm_regfile_w_en),
    .dm_w_req_i (dm_regfile_req_w),
    .wb_w_en_i  (wb_regfile_w_en),
    .wb_w_req_i (wb_regfile_req_w),
    .sel_o      (sel_b),
    .ex_match_o (ex_match_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PHC_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = CTRL_RUN;
    // A load in EX cannot forward its data yet; the ID consumer must wait.
    load_use = ex_is_load && (ex_match_a || ex_match_b);

    unique case (state_q)
      PHC_RUN: begin
        if (dm_busy) begin
          ctrl = CTRL_FREEZE;
        end else if (ex_halt) begin
          // Squash younger instructions and let EX/DM/WB keep retiring.
          ctrl.if_id_clr = 1'b0;
          ctrl.id_ex_clr = 1'b0;
          ctrl.pc_en     = 1'b0;
          state_d        = PHC_DRAIN;
          cnt_d          = DRAIN_LOAD;
        end else if (ex_mispredict) begin
          // Wrong-path instructions in IF/ID and ID/EX are dropped; the PC
          // loads the redirect target, so any load-use in ID is moot.
          ctrl.if_id_clr = 1'b0;
          ctrl.id_ex_clr = 1'b0;
        end else if (load_use) begin
          // Hold PC and IF/ID, push a bubble into ID/EX. Next cycle the load
          // sits in DM and the operand forwards from there.
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_stall = 1'b1;
          ctrl.id_ex_clr   = 1'b0;
        end
      end

      PHC_DRAIN: begin
        if (dm_busy) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl.pc_en     = 1'b0;
          ctrl.if_id_en  = 1'b0;
          ctrl.id_ex_clr = 1'b0;
          if (cnt_q == 2'd0) begin
            state_d = PHC_HALTED;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end

      PHC_HALTED: begin
        ctrl = CTRL_HALTED;
        if (go) begin
          // Resume from a clean front end.
          ctrl.if_id_clr = 1'b0;
          ctrl.id_ex_clr = 1'b0;
          state_d        = PHC_RUN;
        end
      end

      default: begin
        state_d = PHC_RUN;
      end
    endcase

    if (rst) begin
      ctrl = CTRL_RESET;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_stall = ctrl.if_id_stall;
  assign if_id_clr   = ctrl.if_id_clr;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_clr   = ctrl.id_ex_clr;
  assign ex_dm_en    = ctrl.ex_dm_en;
  assign ex_dm_clr   = ctrl.ex_dm_clr;
  assign dm_wb_en    = ctrl.dm_wb_en;
  assign dm_wb_clr   = ctrl.dm_wb_clr;
  assign halted      = ctrl.halted;
  assign redir_a     = rst ? '0 : sel_a;
  assign redir_b     = rst ? '0 : sel_b;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        stall_evt;
  logic        flush_evt;

  // Events mirror which RUN branch actually won this cycle.
  always_comb begin
    stall_evt = (state_q == PHC_RUN) &&
                (dm_busy || (!ex_halt && !ex_mispredict && load_use));
    flush_evt = (state_q == PHC_RUN) && !dm_busy && !ex_halt && ex_mispredict;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (stall_evt) stall_q <= stall_q + 32'd1;
      if (flush_evt) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
//
// Purpose: directed and random stimulus; a behavioural model predicts every
// cycle's outputs into a queue, and a monitor on the falling edge compares.
// Ports: none (top-level bench).
module tb_pipe_hazard_ctrl;

  localparam int HDC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_req_a, id_req_b;
  logic       id_use_a, id_use_b;
  logic       ex_regfile_w_en, ex_is_load;
  logic [4:0] ex_regfile_req_w;
  logic       dm_regfile_w_en, wb_regfile_w_en;
  logic [4:0] dm_regfile_req_w, wb_regfile_req_w;
  logic       ex_mispredict, ex_halt, dm_busy, go;
  logic       pc_en, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr;
  logic       ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, halted;
  logic [1:0] redir_a, redir_b;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REDIR_BIT(2), .HALT_DRAIN_CYCLES(HDC)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count),
`endif
    .id_req_a         (id_req_a),
    .id_req_b         (id_req_b),
    .id_use_a         (id_use_a),
    .id_use_b         (id_use_b),
    .ex_regfile_w_en  (ex_regfile_w_en),
    .ex_regfile_req_w (ex_regfile_req_w),
    .ex_is_load       (ex_is_load),
    .dm_regfile_w_en  (dm_regfile_w_en),
    .dm_regfile_req_w (dm_regfile_req_w),
    .wb_regfile_w_en  (wb_regfile_w_en),
    .wb_regfile_req_w (wb_regfile_req_w),
    .ex_mispredict    (ex_mispredict),
    .ex_halt          (ex_halt),
    .dm_busy          (dm_busy),
    .go               (go),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .if_id_stall      (if_id_stall),
    .if_id_clr        (if_id_clr),
    .id_ex_en         (id_ex_en),
    .id_ex_clr        (id_ex_clr),
    .ex_dm_en         (ex_dm_en),
    .ex_dm_clr        (ex_dm_clr),
    .dm_wb_en         (dm_wb_en),
    .dm_wb_clr        (dm_wb_clr),
    .redir_a          (redir_a),
    .redir_b          (redir_b),
    .halted           (halted)
  );

  typedef struct {
    bit       rst;
    bit [4:0] ra, rb;
    bit       ua, ub;
    bit       exw, ld;
    bit [4:0] exr;
    bit       dmw;
    bit [4:0] dmr;
    bit       wbw;
    bit [4:0] wbr;
    bit       mp, hl, busy, go;
  } stim_t;

  // ctrl order: pc, if_en, stall, if_clr, id_en, id_clr, ex_en, ex_clr, dm_en, dm_clr, halted
  typedef struct packed {
    logic [10:0] ctrl;
    logic [1:0]  ra;
    logic [1:0]  rb;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_issued = 0;

  // Model state: halted flag and number of drain cycles still owed.
  bit m_halted = 1'b0;
  int m_drain  = 0;

  logic [10:0] act_ctrl;
  assign act_ctrl = {pc_en, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr,
                     ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, halted};

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Youngest writer of register r among EX, DM, WB; 0 if none or $0.
  function automatic logic [1:0] fwd(bit u, bit [4:0] r, stim_t s);
    bit [4:0] wr[3];
    bit       we[3];
    if (!u || r == 5'd0) return 2'd0;
    wr = '{s.exr, s.dmr, s.wbr};
    we = '{s.exw, s.dmw, s.wbw};
    for (int k = 0; k < 3; k++) begin
      if (we[k] && wr[k] == r) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit pc, ife, st, ifc, ide, idc, exe, exc, dme, dmc, h;
    logic [1:0] fa, fb;

    rst = s.rst; id_req_a = s.ra; id_req_b = s.rb; id_use_a = s.ua; id_use_b = s.ub;
    ex_regfile_w_en = s.exw; ex_regfile_req_w = s.exr; ex_is_load = s.ld;
    dm_regfile_w_en = s.dmw; dm_regfile_req_w = s.dmr;
    wb_regfile_w_en = s.wbw; wb_regfile_req_w = s.wbr;
    ex_mispredict = s.mp; ex_halt = s.hl; dm_busy = s.busy; go = s.go;

    fa = fwd(s.ua, s.ra, s);
    fb = fwd(s.ub, s.rb, s);
    {pc, ife, st, ifc, ide, idc, exe, exc, dme, dmc, h} = 11'b11011111110;
    if (s.rst) begin
      {pc, ife, st, ifc, ide, idc, exe, exc, dme, dmc, h} = '0;
      fa = 2'd0; fb = 2'd0;
      m_halted = 1'b0; m_drain = 0;
    end else if (m_halted) begin
      {pc, ife, ide, exe, dme} = '0;
      h = 1'b1;
      if (s.go) begin ifc = 1'b0; idc = 1'b0; m_halted = 1'b0; end
    end else if (m_drain > 0) begin
      pc = 1'b0; ife = 1'b0;
      if (s.busy) begin
        ide = 1'b0; exe = 1'b0; dme = 1'b0;
      end else begin
        idc = 1'b0;
        m_drain--;
        if (m_drain == 0) m_halted = 1'b1;
      end
    end else if (s.busy) begin
      {pc, ife, ide, exe, dme} = '0;
    end else if (s.hl) begin
      ifc = 1'b0; idc = 1'b0; pc = 1'b0;
      m_drain = HDC;
    end else if (s.mp) begin
      ifc = 1'b0; idc = 1'b0;
    end else if (s.ld && (fa == 2'd1 || fb == 2'd1)) begin
      pc = 1'b0; st = 1'b1; idc = 1'b0;
    end

    e.ctrl = {pc, ife, st, ifc, ide, idc, exe, exc, dme, dmc, h};
    e.ra   = fa;
    e.rb   = fb;
    e.id   = n_issued;
    n_issued++;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (act_ctrl !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl step=%0d act=%b exp=%b", e.id, act_ctrl, e.ctrl);
      end
      checks++;
      if ({redir_a, redir_b} !== {e.ra, e.rb}) begin
        errors++;
        $display("FAIL redir step=%0d act=%0d/%0d exp=%0d/%0d",
                 e.id, redir_a, redir_b, e.ra, e.rb);
      end
    end
  end

  initial begin
    stim_t s;
    s = quiet();
    s.rst = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(s);
    apply(s);

    // Load-use on $8, then the load moves to DM.
    s = quiet(); s.ra = 5'd8; s.ua = 1'b1; s.exw = 1'b1; s.exr = 5'd8; s.ld = 1'b1;
    apply(s);
    s = quiet(); s.ra = 5'd8; s.ua = 1'b1; s.dmw = 1'b1; s.dmr = 5'd8;
    apply(s);

    // Mispredict beats a simultaneous load-use.
    s = quiet(); s.rb = 5'd5; s.ub = 1'b1; s.exw = 1'b1; s.exr = 5'd5; s.ld = 1'b1; s.mp = 1'b1;
    apply(s);

    // ALU writer of $3 in every stage: EX wins; $0 never forwards; DM and WB alone.
    s = quiet(); s.ra = 5'd3; s.ua = 1'b1; s.rb = 5'd3; s.ub = 1'b1;
    s.exw = 1'b1; s.exr = 5'd3; s.dmw = 1'b1; s.dmr = 5'd3; s.wbw = 1'b1; s.wbr = 5'd3;
    apply(s);
    s.ra = 5'd0; s.exr = 5'd0; s.exw = 1'b1; s.dmr = 5'd0; s.wbr = 5'd0;
    apply(s);
    s = quiet(); s.ra = 5'd3; s.ua = 1'b1; s.rb = 5'd3; s.ub = 1'b1;
    s.dmw = 1'b1; s.dmr = 5'd3; s.wbw = 1'b1; s.wbr = 5'd3;
    apply(s);
    s.dmw = 1'b0;
    apply(s);
    s.ua = 1'b0;
    apply(s);

    // Halt pulse, drain, halted, resume.
    s = quiet(); s.hl = 1'b1; apply(s);
    s = quiet();
    for (int i = 0; i < 4; i++) apply(s);
    s.go = 1'b1; apply(s);
    s.go = 1'b0; apply(s);

    // Halt with data memory busy for 3 drain cycles.
    s = quiet(); s.hl = 1'b1; apply(s);
    s = quiet(); s.busy = 1'b1;
    for (int i = 0; i < 3; i++) apply(s);
    s.busy = 1'b0;
    for (int i = 0; i < 3; i++) apply(s);
    s.go = 1'b1; apply(s);

    // Reset in the middle of a drain, with go also asserted.
    s = quiet(); s.hl = 1'b1; apply(s);
    s = quiet(); apply(s);
    s.rst = 1'b1; s.go = 1'b1; apply(s);
    s.go = 1'b0; apply(s);
    s = quiet(); apply(s);

    // Random traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      s.rst  = ($urandom_range(99) < 2);
      s.ra   = 5'($urandom_range(3));
      s.rb   = 5'($urandom_range(3));
      s.ua   = 1'($urandom_range(1));
      s.ub   = 1'($urandom_range(1));
      s.exw  = 1'($urandom_range(1));
      s.exr  = 5'($urandom_range(3));
      s.ld   = 1'($urandom_range(1));
      s.dmw  = 1'($urandom_range(1));
      s.dmr  = 5'($urandom_range(3));
      s.wbw  = 1'($urandom_range(1));
      s.wbr  = 5'($urandom_range(3));
      s.mp   = ($urandom_range(99) < 12);
      s.hl   = ($urandom_range(99) < 6);
      s.busy = ($urandom_range(99) < 15);
      s.go   = ($urandom_range(99) < 30);
      apply(s);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue act=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
